// File: rtl/axi2per_res_pkg.sv
// Shared types and constants for the AXI-to-peripheral response channel.
package axi2per_res_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        HOLD_B,
        HOLD_R
    } state_e;

    // Number of address bits selecting a 32-bit lane inside one data word.
    function automatic int lane_width(input int data_width);
        return $clog2(data_width / 8) - 2;
    endfunction

endpackage

// File: rtl/axi2per_res_fifo.sv
// Generic register FIFO with full/empty flags and an occupancy count.
module axi2per_res_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/axi2per_res_channel_mo.sv
// Response channel of the AXI-to-peripheral bridge with multiple outstanding transactions.
// Optional AXI2PER_RES_ERR_EN: store peripheral opc and report it as SLVERR on R/B.
//
// state  | meaning
// IDLE   | waiting for both a metadata and a response entry at the FIFO heads
// RESP   | head beat presented (R, B, or both for an ATOP)
// HOLD_B | ATOP: R accepted, B still pending
// HOLD_R | ATOP: B accepted, R still pending
module axi2per_res_channel_mo
    import axi2per_res_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int AXI_ID_WIDTH    = 3,
    parameter int AXI_USER_WIDTH  = 6,
    parameter int NUM_OUTSTANDING = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      per_master_r_valid_i,
    input  logic                      per_master_r_opc_i,
    input  logic [31:0]               per_master_r_rdata_i,
    output logic                      axi_slave_r_valid_o,
    output logic [AXI_DATA_WIDTH-1:0] axi_slave_r_data_o,
    output logic [1:0]                axi_slave_r_resp_o,
    output logic                      axi_slave_r_last_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_slave_r_id_o,
    output logic [AXI_USER_WIDTH-1:0] axi_slave_r_user_o,
    input  logic                      axi_slave_r_ready_i,
    output logic                      axi_slave_b_valid_o,
    output logic [1:0]                axi_slave_b_resp_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_slave_b_id_o,
    output logic [AXI_USER_WIDTH-1:0] axi_slave_b_user_o,
    input  logic                      axi_slave_b_ready_i,
    input  logic                      trans_req_i,
    input  logic                      trans_we_i,
    input  logic                      trans_atop_r_i,
    input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i,
    output logic                      trans_gnt_o,
    output logic                      trans_r_valid_o
);

    localparam int LANE_W   = lane_width(AXI_DATA_WIDTH);
    localparam int LANE_W_S = (LANE_W > 0) ? LANE_W : 1;
    localparam int CNT_W    = $clog2(NUM_OUTSTANDING + 1);

    typedef struct packed {
        logic                    we;
        logic                    atop_r;
        logic [AXI_ID_WIDTH-1:0] id;
        logic [LANE_W_S-1:0]     lane;
    } meta_t;

`ifdef AXI2PER_RES_ERR_EN
    typedef struct packed {
        logic        opc;
        logic [31:0] rdata;
    } resp_t;
`else
    typedef struct packed {
        logic [31:0] rdata;
    } resp_t;
`endif

    meta_t               meta_in, meta_head;
    resp_t               resp_in, resp_head;
    logic                meta_full, meta_empty, resp_full, resp_empty;
    logic [CNT_W-1:0]    meta_cnt, resp_cnt;
    logic                meta_push, resp_push, pop;
    logic [LANE_W_S-1:0] trans_lane;
    logic [1:0]          head_resp;
    logic                unused_sig;

    state_e                    state_q;
    logic                      r_valid_q, b_valid_q, r_last_q;
    logic [AXI_DATA_WIDTH-1:0] r_data_q;
    logic [1:0]                r_resp_q, b_resp_q;
    logic [AXI_ID_WIDTH-1:0]   r_id_q, b_id_q;

    generate
        if (LANE_W > 0) begin : g_lane
            assign trans_lane = trans_add_i[LANE_W+1:2];
        end else begin : g_no_lane
            assign trans_lane = '0;
        end
    endgenerate

    assign meta_in = '{we: trans_we_i, atop_r: trans_atop_r_i, id: trans_id_i, lane: trans_lane};
`ifdef AXI2PER_RES_ERR_EN
    assign resp_in   = '{opc: per_master_r_opc_i, rdata: per_master_r_rdata_i};
    assign head_resp = resp_head.opc ? RESP_SLVERR : RESP_OKAY;
`else
    assign resp_in   = '{rdata: per_master_r_rdata_i};
    assign head_resp = RESP_OKAY;
`endif

    // Grant comes from the registered count only, so a same-cycle pop never widens it.
    assign trans_gnt_o = !meta_full;
    assign meta_push   = trans_req_i && trans_gnt_o;
    assign resp_push   = per_master_r_valid_i && !meta_empty;
    assign pop         = (state_q != IDLE)
                      && (!r_valid_q || axi_slave_r_ready_i)
                      && (!b_valid_q || axi_slave_b_ready_i);
    assign unused_sig  = ^{trans_add_i, per_master_r_opc_i, meta_cnt, resp_cnt, resp_full};

    axi2per_res_fifo #(.WIDTH($bits(meta_t)), .DEPTH(NUM_OUTSTANDING), .CNT_W(CNT_W)) i_meta_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (meta_push),
        .data_i (meta_in),
        .pop_i  (pop),
        .data_o (meta_head),
        .full_o (meta_full),
        .empty_o(meta_empty),
        .count_o(meta_cnt)
    );

    axi2per_res_fifo #(.WIDTH($bits(resp_t)), .DEPTH(NUM_OUTSTANDING), .CNT_W(CNT_W)) i_resp_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (resp_push),
        .data_i (resp_in),
        .pop_i  (pop),
        .data_o (resp_head),
        .full_o (resp_full),
        .empty_o(resp_empty),
        .count_o(resp_cnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            r_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= RESP_OKAY;
            b_resp_q  <= RESP_OKAY;
            r_id_q    <= '0;
            b_id_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!meta_empty && !resp_empty) begin
                        state_q   <= RESP;
                        r_valid_q <= meta_head.we || meta_head.atop_r;
                        b_valid_q <= !meta_head.we;
                        r_last_q  <= 1'b1;
                        r_data_q  <= '0;
                        r_data_q[{meta_head.lane, 5'b0} +: 32] <= resp_head.rdata;
                        r_resp_q  <= head_resp;
                        b_resp_q  <= head_resp;
                        r_id_q    <= meta_head.id;
                        b_id_q    <= meta_head.id;
                    end
                end
                default: begin
                    if (r_valid_q && axi_slave_r_ready_i) r_valid_q <= 1'b0;
                    if (b_valid_q && axi_slave_b_ready_i) b_valid_q <= 1'b0;
                    if (pop)                                   state_q <= IDLE;
                    else if (r_valid_q && axi_slave_r_ready_i) state_q <= HOLD_B;
                    else if (b_valid_q && axi_slave_b_ready_i) state_q <= HOLD_R;
                end
            endcase
        end
    end

    assign axi_slave_r_valid_o = r_valid_q;
    assign axi_slave_r_data_o  = r_data_q;
    assign axi_slave_r_resp_o  = r_resp_q;
    assign axi_slave_r_last_o  = r_last_q;
    assign axi_slave_r_id_o    = r_id_q;
    assign axi_slave_r_user_o  = '0;
    assign axi_slave_b_valid_o = b_valid_q;
    assign axi_slave_b_resp_o  = b_resp_q;
    assign axi_slave_b_id_o    = b_id_q;
    assign axi_slave_b_user_o  = '0;
    assign trans_r_valid_o     = r_valid_q || b_valid_q;

endmodule
